// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, pipeline control inputs and the IF/ID register outputs.
// Handshake: no valid/ready pair here; C_IFID_Valid qualifies the IF/ID fields, C_Stall is backpressure from decode.
interface instruction_fetch_if;
  logic [15:0] A_InstrAddress;
  logic        C_IMRead;
  logic [15:0] D_Instruction;
  logic        C_Stall;
  logic        C_Redirect;
  logic [15:0] D_RedirectAddr;
  logic [15:0] D_IFID_Instr;
  logic [15:0] D_IFID_PC;
  logic [15:0] D_IFID_PCNext;
  logic        C_IFID_Valid;
  logic        C_Halted;
  logic [1:0]  dbg_state;

  modport master (
    output A_InstrAddress, C_IMRead, D_IFID_Instr, D_IFID_PC, D_IFID_PCNext,
           C_IFID_Valid, C_Halted, dbg_state,
    input  D_Instruction, C_Stall, C_Redirect, D_RedirectAddr
  );

  modport slave (
    input  A_InstrAddress, C_IMRead, D_IFID_Instr, D_IFID_PC, D_IFID_PCNext,
           C_IFID_Valid, C_Halted, dbg_state,
    output D_Instruction, C_Stall, C_Redirect, D_RedirectAddr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, instruction-memory address/enable, IF/ID pipeline register,
// with stall, redirect+flush and a halt opcode that parks fetch until redirect or reset.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input logic                   clk,
  input logic                   rst,
  instruction_fetch_if.master   if_bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic [15:0] ifid_pcn_q, ifid_pcn_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      ifid_pc_q  <= 16'h0000;
      ifid_pcn_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pcn_q <= ifid_pcn_d;
      valid_q    <= valid_d;
    end
  end

  // Priority: redirect, then stall, then the per-state action (halt detect lives in RUN).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_pcn_d = ifid_pcn_q;
    valid_d    = valid_q;
    if (if_bus.C_Redirect) begin
      state_d    = S_RUN;
      pc_d       = if_bus.D_RedirectAddr;
      instr_d    = 16'h0000;
      ifid_pc_d  = 16'h0000;
      ifid_pcn_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (if_bus.C_Stall) begin
      // BOOT is a single bubble cycle regardless of stall.
      if (state_q == S_BOOT) state_d = S_RUN;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          instr_d    = if_bus.D_Instruction;
          ifid_pc_d  = pc_q;
          ifid_pcn_d = pc_q + 16'd1;
          valid_d    = 1'b1;
          pc_d       = pc_q + 16'd1;
          if (if_bus.D_Instruction[15:12] == HALT_OPCODE) state_d = S_HALT;
        end
        S_HALT: begin
          instr_d = 16'h0000;
          valid_d = 1'b0;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    if_bus.A_InstrAddress = pc_q;
    if_bus.C_IMRead       = (state_q != S_HALT);
    if_bus.C_Halted       = (state_q == S_HALT);
    if_bus.D_IFID_Instr   = instr_q;
    if_bus.D_IFID_PC      = ifid_pc_q;
    if_bus.D_IFID_PCNext  = ifid_pcn_q;
    if_bus.C_IFID_Valid   = valid_q;
    if_bus.dbg_state      = state_q;
  end

endmodule
